// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory target for the core: byte-writable RAM plus an MMIO
//            block (debug TX FIFO, GPIO, cycle counter, compare timer).
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int RAM_AW    = 10,
    parameter int DBG_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        data_mem_we,
    input  logic [3:0]  data_mem_be,
    input  logic [29:0] data_mem_addr,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic [7:0]  dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int c_PTR_W = $clog2(DBG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DBG_DEPTH);

    localparam logic [3:0] c_OFF_DBG   = 4'd0;
    localparam logic [3:0] c_OFF_GPIO  = 4'd1;
    localparam logic [3:0] c_OFF_CYCLE = 4'd2;
    localparam logic [3:0] c_OFF_CMP   = 4'd3;
    localparam logic [3:0] c_OFF_IRQ   = 4'd4;
    localparam logic [3:0] c_OFF_CTRL  = 4'd5;

    logic [31:0]        r_ram [0:(1<<RAM_AW)-1];
    logic [7:0]         r_fifo [0:DBG_DEPTH-1];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic [7:0]         r_gpio;
    logic [31:0]        r_cycle;
    logic [31:0]        r_cmp;
    logic               r_cmp_en;
    logic               r_irq;
    logic [31:0]        r_rdata;

    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_is_mmio;
    logic [3:0]         w_off;
    logic               w_mmio_wr;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_req;
    logic               w_do_push;
    logic               w_ovf_set;
    logic               w_irq_set;
    logic               w_irq_wr;
    logic [7:0]         w_count8;
    logic [31:0]        w_mmio_rd;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    assign w_ram_idx = data_mem_addr[RAM_AW-1:0];
    assign w_is_mmio = data_mem_addr[29];
    assign w_off     = data_mem_addr[3:0];
    assign w_mmio_wr = data_mem_we & w_is_mmio;
    // Upper address bits alias in RAM and are don't-care in MMIO.
    assign w_unused  = ^{data_mem_addr[28:RAM_AW]};

    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & dbg_ready;
    assign w_push_req = w_mmio_wr & (w_off == c_OFF_DBG) & data_mem_be[0];
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_do_push  = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_irq_set  = r_cmp_en & (r_cycle == r_cmp);
    assign w_irq_wr   = w_mmio_wr & (w_off == c_OFF_IRQ) & data_mem_be[0];
    assign w_count8   = 8'(r_count);

    assign dbg_data       = r_fifo[r_rptr];
    assign dbg_valid      = ~w_empty;
    assign gpio_out       = r_gpio;
    assign timer_irq      = r_irq;
    assign data_mem_rdata = r_rdata;

    always_comb begin
        w_mmio_rd = 32'd0;
        case (w_off)
            c_OFF_DBG:   w_mmio_rd = {16'd0, w_count8, 5'd0, r_ovf, w_full, w_empty};
            c_OFF_GPIO:  w_mmio_rd = {24'd0, r_gpio};
            c_OFF_CYCLE: w_mmio_rd = r_cycle;
            c_OFF_CMP:   w_mmio_rd = r_cmp;
            c_OFF_IRQ:   w_mmio_rd = {30'd0, r_ovf, r_irq};
            c_OFF_CTRL:  w_mmio_rd = {31'd0, r_cmp_en};
            default:     w_mmio_rd = 32'd0;
        endcase
    end

    assign w_rd_data = w_is_mmio ? w_mmio_rd : r_ram[w_ram_idx];

    // Storage arrays are not reset; only pointers and flags are.
    always_ff @(posedge CLK) begin
        if (data_mem_we && !w_is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_mem_be[i]) r_ram[w_ram_idx][8*i +: 8] <= data_mem_wdata[8*i +: 8];
            end
        end
        if (w_do_push) r_fifo[r_wptr] <= data_mem_wdata[7:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rdata  <= 32'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_gpio   <= 8'd0;
            r_cycle  <= 32'd0;
            r_cmp    <= 32'hFFFF_FFFF;
            r_cmp_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rdata <= w_rd_data;
            r_cycle <= r_cycle + 32'd1;

            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_pop) r_count <= r_count - 1'b1;

            if (w_ovf_set)                          r_ovf <= 1'b1;
            else if (w_irq_wr && data_mem_wdata[1]) r_ovf <= 1'b0;

            if (w_irq_set)                          r_irq <= 1'b1;
            else if (w_irq_wr && data_mem_wdata[0]) r_irq <= 1'b0;

            if (w_mmio_wr && (w_off == c_OFF_GPIO) && data_mem_be[0])
                r_gpio <= data_mem_wdata[7:0];
            if (w_mmio_wr && (w_off == c_OFF_CTRL) && data_mem_be[0])
                r_cmp_en <= data_mem_wdata[0];
            if (w_mmio_wr && (w_off == c_OFF_CMP)) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_mem_be[i]) r_cmp[8*i +: 8] <= data_mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder with read/FIFO queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam logic [29:0] c_MMIO = 30'h2000_0000;

    logic        CLK;
    logic        RESET;
    logic        data_mem_we;
    logic [3:0]  data_mem_be;
    logic [29:0] data_mem_addr;
    logic [31:0] data_mem_wdata;
    logic [31:0] data_mem_rdata;
    logic [7:0]  dbg_data;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int          n_checks;
    int          n_fail;
    logic [31:0] rd_q[$];
    logic [7:0]  fifo_q[$];
    logic        m_ovf;
    logic [31:0] m_cycle;

    data_mem_responder #(.RAM_AW(10), .DBG_DEPTH(8)) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .data_mem_we    (data_mem_we),
        .data_mem_be    (data_mem_be),
        .data_mem_addr  (data_mem_addr),
        .data_mem_wdata (data_mem_wdata),
        .data_mem_rdata (data_mem_rdata),
        .dbg_data       (dbg_data),
        .dbg_valid      (dbg_valid),
        .dbg_ready      (dbg_ready),
        .gpio_out       (gpio_out),
        .timer_irq      (timer_irq)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference cycle counter: counts edges since the last reset release.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) m_cycle <= 32'd0;
        else       m_cycle <= m_cycle + 32'd1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Drives one access, then returns #1 after the edge that consumed it.
    task automatic bus_cycle(input logic we, input logic [3:0] be,
                             input logic [29:0] addr, input logic [31:0] wdata);
        data_mem_we    = we;
        data_mem_be    = be;
        data_mem_addr  = addr;
        data_mem_wdata = wdata;
        @(posedge CLK);
        #1;
        data_mem_we = 1'b0;
        data_mem_be = 4'b0;
    endtask

    function automatic logic [31:0] status_word();
        int n;
        n = fifo_q.size();
        return {16'd0, 8'(n), 5'd0, m_ovf, (n == 8), (n == 0)};
    endfunction

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] exp;
        #1;
        n_checks++;
        if (data_mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", data_mem_rdata, 32'd0); end
        n_checks++;
        if (gpio_out !== 8'd0) begin n_fail++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 8'd0); end
        n_checks++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        n_checks++;
        if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dbg_valid); end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        rd_q.push_back(32'hFFFF_FFFF);
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'd3, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_cmp: got %h expected %h", got, exp); end
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'd0, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_status: got %h expected %h", got, exp); end
    endtask

    task automatic test_ram();
        logic [31:0] got;
        logic [31:0] exp;
        bus_cycle(1'b1, 4'b1111, 30'd5, 32'h1122_3344);
        bus_cycle(1'b1, 4'b0101, 30'd5, 32'hAABB_CCDD);
        rd_q.push_back(32'h11BB_33DD);
        bus_cycle(1'b0, 4'b0, 30'd5, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ram_bytes: got %h expected %h", got, exp); end
        rd_q.push_back(32'h11BB_33DD);
        bus_cycle(1'b0, 4'b0, 30'd5 + 30'd1024, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ram_alias: got %h expected %h", got, exp); end
        rd_q.push_back(32'h11BB_33DD);
        bus_cycle(1'b1, 4'b1111, 30'd5, 32'hFFFF_FFFF);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ram_rbw: got %h expected %h", got, exp); end
        rd_q.push_back(32'hFFFF_FFFF);
        bus_cycle(1'b0, 4'b0, 30'd5, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ram_after_write: got %h expected %h", got, exp); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  eb;
        dbg_ready = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            if (fifo_q.size() < 8) fifo_q.push_back(8'(b));
            else                   m_ovf = 1'b1;
            bus_cycle(1'b1, 4'b0001, c_MMIO, 32'(b));
        end
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp || exp !== 32'h0000_0806) begin n_fail++; $display("FAIL fifo_status_full: got %h expected %h", got, 32'h0000_0806); end
        dbg_ready = 1'b1;
        for (int k = 0; k < 16 && fifo_q.size() > 0; k++) begin
            eb = fifo_q.pop_front();
            n_checks++;
            if (dbg_valid !== 1'b1 || dbg_data !== eb) begin
                n_fail++; $display("FAIL fifo_drain: got valid=%b data=%h expected valid=1 data=%h", dbg_valid, dbg_data, eb);
            end
            bus_cycle(1'b0, 4'b0, 30'd0, 32'd0);
        end
        n_checks++;
        if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty_after_drain: got valid=%b data=%h expected valid=0", dbg_valid, dbg_data); end
        dbg_ready = 1'b0;
        m_ovf = 1'b0;
        bus_cycle(1'b1, 4'b0001, c_MMIO | 30'd4, 32'd2);
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h expected %h", got, exp); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  eb;
        for (int b = 8'h20; b < 8'h28; b++) begin
            fifo_q.push_back(8'(b));
            bus_cycle(1'b1, 4'b0001, c_MMIO, 32'(b));
        end
        dbg_ready = 1'b1;
        eb = fifo_q.pop_front();
        fifo_q.push_back(8'h55);
        n_checks++;
        if (dbg_data !== eb) begin n_fail++; $display("FAIL fifo_pushpop_head: got %h expected %h", dbg_data, eb); end
        bus_cycle(1'b1, 4'b0001, c_MMIO, 32'h55);
        dbg_ready = 1'b0;
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL fifo_pushpop_status: got %h expected %h", got, exp); end
        dbg_ready = 1'b1;
        for (int k = 0; k < 16 && fifo_q.size() > 0; k++) begin
            eb = fifo_q.pop_front();
            n_checks++;
            if (dbg_valid !== 1'b1 || dbg_data !== eb) begin
                n_fail++; $display("FAIL fifo_pushpop_drain: got valid=%b data=%h expected valid=1 data=%h", dbg_valid, dbg_data, eb);
            end
            bus_cycle(1'b0, 4'b0, 30'd0, 32'd0);
        end
        n_checks++;
        if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_pushpop_empty: got valid=%b expected 0", dbg_valid); end
        dbg_ready = 1'b0;
    endtask

    task automatic test_timer();
        logic [31:0] got;
        logic [31:0] exp;
        logic [31:0] cmp_val;
        logic [31:0] pre;
        logic        hit;
        cmp_val = m_cycle + 32'd12;
        hit = 1'b0;
        bus_cycle(1'b1, 4'b1111, c_MMIO | 30'd3, cmp_val);
        bus_cycle(1'b1, 4'b0001, c_MMIO | 30'd5, 32'd1);
        for (int k = 0; k < 20; k++) begin
            pre = m_cycle;
            if (pre == cmp_val) hit = 1'b1;
            rd_q.push_back(pre);
            bus_cycle(1'b0, 4'b0, c_MMIO | 30'd2, 32'd0);
            got = data_mem_rdata; exp = rd_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL timer_cycle: got %h expected %h", got, exp); end
            n_checks++;
            if (timer_irq !== hit) begin n_fail++; $display("FAIL timer_irq_edge: got %b expected %b at cycle %h", timer_irq, hit, pre); end
        end
        rd_q.push_back(32'd1);
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'd4, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL timer_irq_reg: got %h expected %h", got, exp); end
        bus_cycle(1'b1, 4'b0001, c_MMIO | 30'd4, 32'd1);
        n_checks++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_clear: got %b expected 0", timer_irq); end
    endtask

    task automatic test_collision();
        logic [31:0] got;
        logic [31:0] exp;
        rd_q.push_back(32'd0);
        bus_cycle(1'b1, 4'b0001, c_MMIO | 30'd1, 32'h0000_00A5);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL gpio_rbw: got %h expected %h", got, exp); end
        n_checks++;
        if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out: got %h expected %h", gpio_out, 8'hA5); end
        rd_q.push_back(32'h0000_00A5);
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'h0012_3401, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL gpio_read_alias: got %h expected %h", got, exp); end
        bus_cycle(1'b1, 4'b0000, c_MMIO, 32'h77);
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL be0_no_push: got %h expected %h", got, exp); end
        rd_q.push_back(32'd0);
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'd9, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", got, exp); end
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        logic [31:0] exp;
        for (int b = 1; b <= 3; b++) bus_cycle(1'b1, 4'b0001, c_MMIO, 32'(b));
        bus_cycle(1'b1, 4'b1111, c_MMIO | 30'd3, m_cycle + 32'd2);
        for (int k = 0; k < 4; k++) bus_cycle(1'b0, 4'b0, c_MMIO | 30'd1, 32'd0);
        n_checks++;
        if (timer_irq !== 1'b1 || dbg_valid !== 1'b1) begin
            n_fail++; $display("FAIL prereset_state: got irq=%b valid=%b expected irq=1 valid=1", timer_irq, dbg_valid);
        end
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (dbg_valid !== 1'b0 || timer_irq !== 1'b0 || gpio_out !== 8'd0 || data_mem_rdata !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got valid=%b irq=%b gpio=%h rdata=%h expected all zero",
                               dbg_valid, timer_irq, gpio_out, data_mem_rdata);
        end
        #1 RESET = 1'b0;
        fifo_q.delete();
        m_ovf = 1'b0;
        rd_q.push_back(m_cycle);
        bus_cycle(1'b0, 4'b0, c_MMIO | 30'd2, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp || exp !== 32'd0) begin n_fail++; $display("FAIL cycle_restart: got %h expected %h", got, 32'd0); end
        rd_q.push_back(status_word());
        bus_cycle(1'b0, 4'b0, c_MMIO, 32'd0);
        got = data_mem_rdata; exp = rd_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_fifo_status: got %h expected %h", got, exp); end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        m_ovf          = 1'b0;
        RESET          = 1'b1;
        dbg_ready      = 1'b0;
        data_mem_we    = 1'b0;
        data_mem_be    = 4'b0;
        data_mem_addr  = 30'd0;
        data_mem_wdata = 32'd0;
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_full_push_pop();
        test_timer();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
